// File: rtl/nes_joy_pkg.sv
// Shared types and constants for the NES controller ports at $4016/$4017.
// Button bit order in a pad vector, bit0 first: A,B,Select,Start,Up,Down,Left,Right.
package nes_joy_pkg;

  typedef enum logic [2:0] {
    BTN_A, BTN_B, BTN_SELECT, BTN_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
  } btn_e;

  localparam int NUM_BTN = 8;
  localparam int NUM_KC  = 4;

  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;

  // Pad1: K J Space Enter W S A D
  localparam logic [7:0] KC1_A = 8'h0E, KC1_B = 8'h0D, KC1_SEL = 8'h2C, KC1_START = 8'h28;
  localparam logic [7:0] KC1_UP = 8'h1A, KC1_DOWN = 8'h16, KC1_LEFT = 8'h04, KC1_RIGHT = 8'h07;
  // Pad2: M N ] [ and the arrow keys
  localparam logic [7:0] KC2_A = 8'h10, KC2_B = 8'h11, KC2_SEL = 8'h30, KC2_START = 8'h2F;
  localparam logic [7:0] KC2_UP = 8'h52, KC2_DOWN = 8'h51, KC2_LEFT = 8'h50, KC2_RIGHT = 8'h4F;

  typedef logic [NUM_BTN-1:0][7:0] kc_map_t;

  // Index by btn_e; rightmost entry is BTN_A.
  localparam kc_map_t PAD1_MAP = {KC1_RIGHT, KC1_LEFT, KC1_DOWN, KC1_UP,
                                  KC1_START, KC1_SEL, KC1_B, KC1_A};
  localparam kc_map_t PAD2_MAP = {KC2_RIGHT, KC2_LEFT, KC2_DOWN, KC2_UP,
                                  KC2_START, KC2_SEL, KC2_B, KC2_A};
  localparam logic [1:0][NUM_BTN-1:0][7:0] PAD_MAPS = {PAD2_MAP, PAD1_MAP};

  typedef struct packed {
    logic wr_joy1;
    logic rd_joy1;
    logic rd_joy2;
  } bus_req_t;

endpackage

// File: rtl/joypad_shift.sv
// One controller's 4021-style shift register: parallel load while strobe is high,
// otherwise shift right on each read, filling with 1s.
import nes_joy_pkg::*;

module joypad_shift (
  input  logic               cpu_clk,
  input  logic               reset_n,
  input  logic               strobe,
  input  logic [NUM_BTN-1:0] load,
  input  logic               shift_en,
  output logic               q0
);

  logic [NUM_BTN-1:0] sr;

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n)      sr <= '0;
    else if (strobe)   sr <= load;
    else if (shift_en) sr <= {1'b1, sr[NUM_BTN-1:1]};
  end

  assign q0 = sr[0];

endmodule

// File: rtl/joypad_port.sv
// CPU-side responder for the NES controller ports: HID keycode decode, 2-flop sync,
// strobe register, serial read-out through D0. Define JOYPAD2_EN to populate pad2 at $4017.
import nes_joy_pkg::*;

module joypad_port #(
  parameter int         KC_W    = 8,
  parameter logic [7:0] IDLE_HI = 8'h40
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_wr_n,
  input  logic [31:0] keycode,
  output logic [7:0]  bus_out,
  output logic        bus_out_en
);

`ifdef JOYPAD2_EN
  localparam int NUM_PADS = 2;
`else
  localparam int NUM_PADS = 1;
`endif

  logic [NUM_PADS-1:0][NUM_BTN-1:0] btn_raw, btn_s1, btn_s2;
  logic [NUM_PADS-1:0]              q0, rd_hit;
  logic                             strobe, rd_bit;
  bus_req_t                         req;
  logic [6:0]                       unused_din;

  assign unused_din = bus_din[7:1];

  assign req.wr_joy1 = !bus_wr_n && (bus_addr == JOY1_ADDR);
  assign req.rd_joy1 =  bus_wr_n && (bus_addr == JOY1_ADDR);
  assign req.rd_joy2 =  bus_wr_n && (bus_addr == JOY2_ADDR);

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [NUM_BTN-1:0] dec;

    // A button is down if any of the four report slots carries its code; 00 = empty slot.
    always_comb begin
      dec = '0;
      for (int b = 0; b < NUM_BTN; b++)
        for (int k = 0; k < NUM_KC; k++)
          if (keycode[k*KC_W +: KC_W] != '0 && keycode[k*KC_W +: KC_W] == PAD_MAPS[p][b])
            dec[b] = 1'b1;
    end

    assign btn_raw[p] = dec;
    assign rd_hit[p]  = bus_wr_n && (bus_addr == JOY1_ADDR + 16'(p));

    joypad_shift u_shift (
      .cpu_clk  (cpu_clk),
      .reset_n  (reset_n),
      .strobe   (strobe),
      .load     (btn_s2[p]),
      .shift_en (rd_hit[p]),
      .q0       (q0[p])
    );
  end

  // keycode comes from the NIOS domain; the decoded vector is synchronised, not the raw word.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      strobe <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      if (req.wr_joy1) strobe <= bus_din[0];
    end
  end

  always_comb begin
    rd_bit = 1'b0;
    for (int p = 0; p < NUM_PADS; p++)
      if (rd_hit[p]) rd_bit = q0[p];
  end

  // An unpopulated $4017 still answers, reading as open bus only.
  assign bus_out_en = req.rd_joy1 | req.rd_joy2;
  assign bus_out    = IDLE_HI | {7'b0, rd_bit};

endmodule

// File: tb/tb_joypad_port.sv
// Scoreboard bench for joypad_port: expectations queued at drive time, popped at sample time.
module tb_joypad_port;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bus_addr = 16'h0000;
  logic [7:0]  bus_din = 8'h00;
  logic        bus_wr_n = 1'b1;
  logic [31:0] keycode = 32'h0;
  logic [7:0]  bus_out;
  logic        bus_out_en;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  joypad_port dut (
    .cpu_clk   (cpu_clk),
    .reset_n   (reset_n),
    .bus_addr  (bus_addr),
    .bus_din   (bus_din),
    .bus_wr_n  (bus_wr_n),
    .keycode   (keycode),
    .bus_out   (bus_out),
    .bus_out_en(bus_out_en)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference button decode, written as a lookup per keycode byte.
  function automatic logic [7:0] model_pad(input logic [31:0] kc, input int pad);
    logic [7:0] r, b;
    r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      b = kc[k*8 +: 8];
      if (pad == 0) begin
        case (b)
          8'h0E: r[0] = 1'b1; 8'h0D: r[1] = 1'b1; 8'h2C: r[2] = 1'b1; 8'h28: r[3] = 1'b1;
          8'h1A: r[4] = 1'b1; 8'h16: r[5] = 1'b1; 8'h04: r[6] = 1'b1; 8'h07: r[7] = 1'b1;
          default: ;
        endcase
      end else begin
        case (b)
          8'h10: r[0] = 1'b1; 8'h11: r[1] = 1'b1; 8'h30: r[2] = 1'b1; 8'h2F: r[3] = 1'b1;
          8'h52: r[4] = 1'b1; 8'h51: r[5] = 1'b1; 8'h50: r[6] = 1'b1; 8'h4F: r[7] = 1'b1;
          default: ;
        endcase
      end
    end
    return r;
  endfunction

  // One bus cycle starting just after a rising edge; returns {bus_out_en, bus_out} at mid-cycle.
  task automatic bus_cycle(input logic [15:0] a, input logic wr_n, input logic [7:0] d,
                           output logic [8:0] obs);
    bus_addr = a; bus_wr_n = wr_n; bus_din = d;
    @(negedge cpu_clk);
    obs = {bus_out_en, bus_out};
    @(posedge cpu_clk); #1;
    bus_addr = 16'h0000; bus_wr_n = 1'b1; bus_din = 8'h00;
  endtask

  // Idle cycles with the bus parked on an unowned address.
  task automatic idle(input int n);
    repeat (n) begin @(posedge cpu_clk); #1; end
  endtask

  task automatic strobe_pulse();
    logic [8:0] o;
    bus_cycle(16'h4016, 1'b0, 8'h01, o);
    bus_cycle(16'h4016, 1'b0, 8'h00, o);
  endtask

  task automatic test_reset();
    logic [8:0] o, e;
    keycode = 32'h0;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(1);
    exp_q.push_back({1'b1, 8'h40});
    bus_cycle(16'h4016, 1'b1, 8'h00, o);
    e = exp_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_read4016 got=%h want=%h", o, e); end
    exp_q.push_back({1'b0, 8'h40});
    bus_cycle(16'h0000, 1'b1, 8'h00, o);
    e = exp_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_read0000 got=%h want=%h", o, e); end
  endtask

  task automatic test_single_press();
    logic [8:0] o, e;
    logic [7:0] seq [9];
    seq = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};
    keycode = 32'h0000000E;
    idle(2);
    exp_q.push_back({1'b0, 8'h40});
    bus_cycle(16'h4016, 1'b0, 8'h01, o);
    e = exp_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL write_cycle_out got=%h want=%h", o, e); end
    bus_cycle(16'h4016, 1'b0, 8'h00, o);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({1'b1, seq[i]});
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL single_press_read%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_pattern();
    logic [8:0] o, e;
    logic [7:0] btn;
    keycode = {8'h1A, 8'h07, 8'h28, 8'h00};
    btn = model_pad(keycode, 0);
    idle(3);
    strobe_pulse();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 7'h20, btn[i]});
    for (int i = 0; i < 8; i++) begin
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL pattern_bit%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_strobe_held();
    logic [8:0] o, e;
    keycode = 32'h0000000E;
    idle(3);
    bus_cycle(16'h4016, 1'b0, 8'h01, o);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 8'h41});
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL strobe_held_read%0d got=%h want=%h", i, o, e); end
    end
    // Release K at the start of cycle 0; only cycle 3 may show it.
    keycode = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, (i < 3) ? 8'h41 : 8'h40});
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL release_latency_cyc%0d got=%h want=%h", i, o, e); end
    end
    bus_cycle(16'h4016, 1'b0, 8'h00, o);
  endtask

  task automatic test_pad2();
    logic [8:0] o, e;
    logic [7:0] btn;
    keycode = 32'h00000052;
    idle(3);
    strobe_pulse();
`ifdef JOYPAD2_EN
    btn = model_pad(keycode, 1);
`else
    btn = 8'h00;
`endif
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b1, 7'h20, btn[i]});
      bus_cycle(16'h4017, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL pad2_read%0d got=%h want=%h", i, o, e); end
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b1, 8'h40});
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL pad2_pad1_read%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] o, e;
    logic [7:0] seq [3];
    seq = '{8'h41, 8'h40, 8'h40};
    keycode = 32'h0000000E;
    idle(3);
    strobe_pulse();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, seq[i]});
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL pre_reset_read%0d got=%h want=%h", i, o, e); end
    end
    // Leave strobe high so a reset that fails to clear it shows up as a reload of K.
    bus_cycle(16'h4016, 1'b0, 8'h01, o);
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge cpu_clk); #1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 8'h40});
      bus_cycle(16'h4016, 1'b1, 8'h00, o);
      e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL post_reset_read%0d got=%h want=%h", i, o, e); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_press();
    test_pattern();
    test_strobe_held();
    test_pad2();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
